// File: rtl/time_reporter_pkg.sv
// time_reporter_pkg: shared constants, state encoding and the digit-to-ASCII
// helper for the ASCII time reporter. The optional ':' separators are enabled
// with the TIME_REPORTER_COLON_EN macro.
package time_reporter_pkg;

    localparam logic [7:0] ASCII_ZERO  = 8'h30;
    localparam logic [7:0] ASCII_COLON = 8'h3A;
    localparam logic [7:0] ASCII_QMARK = 8'h3F;
    localparam logic [7:0] ASCII_LF    = 8'h0A;

    localparam int FRAME_LEN_BASE  = 7;
    localparam int FRAME_LEN_COLON = 9;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_SEND = 1'b1
    } state_t;

    typedef struct packed {
        logic [3:0] hr_tens;
        logic [3:0] hr_ones;
        logic [3:0] min_tens;
        logic [3:0] min_ones;
        logic [3:0] sec_tens;
        logic [3:0] sec_ones;
    } time_bcd_t;

    // Digits above 9 are not valid BCD and go out as '?' so the receiver can spot them.
    function automatic logic [7:0] bcd_to_ascii(input logic [3:0] d);
        if (d > 4'd9) begin
            return ASCII_QMARK;
        end
        return ASCII_ZERO + {4'h0, d};
    endfunction

endpackage

// File: rtl/time_reporter_if.sv
// time_reporter_if: valid/ready byte stream from the time reporter to uart_tx.
// The master drives bytes and valid; the slave answers with ready.
interface time_reporter_if;

    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready;

    modport master (
        output tx_data,
        output tx_valid,
        input  tx_ready
    );

    modport slave (
        input  tx_data,
        input  tx_valid,
        output tx_ready
    );

endinterface

// File: rtl/time_reporter.sv
// time_reporter: snapshots the BCD time on a request (send, or sec_tick when
// AUTO_REPORT=1) and streams it as "HHMMSS" + TERM_CHAR over a valid/ready
// byte handshake. Defining TIME_REPORTER_COLON_EN inserts ':' after the hours
// and minutes, giving the 9-byte "HH:MM:SS" frame.
module time_reporter
    import time_reporter_pkg::*;
#(
    parameter bit         AUTO_REPORT = 1'b0,
    parameter logic [7:0] TERM_CHAR   = 8'h0A
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   send,
    input  logic                   sec_tick,
    input  logic [3:0]             hr_tens,
    input  logic [3:0]             hr_ones,
    input  logic [3:0]             min_tens,
    input  logic [3:0]             min_ones,
    input  logic [3:0]             sec_tens,
    input  logic [3:0]             sec_ones,
    time_reporter_if.master        tx,
    output logic                   busy,
    output logic                   done
);

`ifdef TIME_REPORTER_COLON_EN
    localparam int FRAME_LEN = FRAME_LEN_COLON;
`else
    localparam int FRAME_LEN = FRAME_LEN_BASE;
`endif
    localparam logic [3:0] LAST_IDX = 4'(FRAME_LEN - 1);

    state_t     state;
    state_t     state_next;
    time_bcd_t  snap;
    time_bcd_t  live;
    logic [3:0] idx;
    logic       pending;
    logic       done_r;
    logic       trig;
    logic       accept;
    logic       frame_end;
    logic       restart;
    logic       tx_valid_int;
    logic [7:0] tx_data_int;
    logic [7:0] byte_sel;

    assign live = '{hr_tens:  hr_tens,  hr_ones:  hr_ones,
                    min_tens: min_tens, min_ones: min_ones,
                    sec_tens: sec_tens, sec_ones: sec_ones};

    // A simultaneous send and sec_tick collapse into one request.
    assign trig      = send | (AUTO_REPORT & sec_tick);
    assign accept    = tx_valid_int & tx.tx_ready;
    assign frame_end = accept && (idx == LAST_IDX);
    // A trigger landing on the terminator accept chains straight into another frame.
    assign restart   = pending | trig;

    assign tx.tx_valid = tx_valid_int;
    assign tx.tx_data  = tx_data_int;
    assign done        = done_r;

    // State register; reset abandons any frame in flight.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next state: leave IDLE on a request, return only when the frame ends with nothing queued.
    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE: begin
                if (trig) begin
                    state_next = ST_SEND;
                end
            end
            ST_SEND: begin
                if (frame_end && !restart) begin
                    state_next = ST_IDLE;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    // Snapshot, byte index, pending flag and done pulse.
    always_ff @(posedge clk) begin
        if (reset) begin
            snap    <= '0;
            idx     <= 4'd0;
            pending <= 1'b0;
            done_r  <= 1'b0;
        end else begin
            done_r <= frame_end;
            case (state)
                ST_IDLE: begin
                    if (trig) begin
                        snap <= live;
                        idx  <= 4'd0;
                    end
                end
                ST_SEND: begin
                    if (frame_end) begin
                        idx     <= 4'd0;
                        pending <= 1'b0;
                        if (restart) begin
                            snap <= live;
                        end
                    end else begin
                        if (accept) begin
                            idx <= idx + 4'd1;
                        end
                        if (trig) begin
                            pending <= 1'b1;
                        end
                    end
                end
                default: begin
                    idx <= 4'd0;
                end
            endcase
        end
    end

    // Pick the frame byte addressed by idx from the frozen snapshot.
    always_comb begin
        byte_sel = 8'h00;
`ifdef TIME_REPORTER_COLON_EN
        case (idx)
            4'd0:    byte_sel = bcd_to_ascii(snap.hr_tens);
            4'd1:    byte_sel = bcd_to_ascii(snap.hr_ones);
            4'd2:    byte_sel = ASCII_COLON;
            4'd3:    byte_sel = bcd_to_ascii(snap.min_tens);
            4'd4:    byte_sel = bcd_to_ascii(snap.min_ones);
            4'd5:    byte_sel = ASCII_COLON;
            4'd6:    byte_sel = bcd_to_ascii(snap.sec_tens);
            4'd7:    byte_sel = bcd_to_ascii(snap.sec_ones);
            4'd8:    byte_sel = TERM_CHAR;
            default: byte_sel = 8'h00;
        endcase
`else
        case (idx)
            4'd0:    byte_sel = bcd_to_ascii(snap.hr_tens);
            4'd1:    byte_sel = bcd_to_ascii(snap.hr_ones);
            4'd2:    byte_sel = bcd_to_ascii(snap.min_tens);
            4'd3:    byte_sel = bcd_to_ascii(snap.min_ones);
            4'd4:    byte_sel = bcd_to_ascii(snap.sec_tens);
            4'd5:    byte_sel = bcd_to_ascii(snap.sec_ones);
            4'd6:    byte_sel = TERM_CHAR;
            default: byte_sel = 8'h00;
        endcase
`endif
    end

    // Outputs follow the state: a byte is offered for as long as a frame is in progress.
    always_comb begin
        tx_valid_int = 1'b0;
        busy         = 1'b0;
        tx_data_int  = 8'h00;
        if (state == ST_SEND) begin
            tx_valid_int = 1'b1;
            busy         = 1'b1;
            tx_data_int  = byte_sel;
        end
    end

endmodule

// File: tb/tb_time_reporter.sv
// tb_time_reporter: directed scenarios followed by randomized traffic. A
// frame-level reference model queues the expected bytes when a frame starts;
// a monitor pops them on each accepted byte. Build with TIME_REPORTER_COLON_EN
// defined to exercise the 9-byte frame.
module tb_time_reporter;

`ifdef TIME_REPORTER_COLON_EN
    localparam int FLEN = 9;
`else
    localparam int FLEN = 7;
`endif

    logic       clk;
    logic       reset;
    logic       send;
    logic       sec_tick;
    logic [3:0] hr_tens, hr_ones, min_tens, min_ones, sec_tens, sec_ones;
    logic       busy;
    logic       done;

    time_reporter_if tx();

    time_reporter #(
        .AUTO_REPORT (1'b1),
        .TERM_CHAR   (8'h0A)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .send     (send),
        .sec_tick (sec_tick),
        .hr_tens  (hr_tens),
        .hr_ones  (hr_ones),
        .min_tens (min_tens),
        .min_ones (min_ones),
        .sec_tens (sec_tens),
        .sec_ones (sec_ones),
        .tx       (tx),
        .busy     (busy),
        .done     (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;
    int dut_done_cnt = 0;
    int m_done_cnt   = 0;

    logic [7:0] exp_q[$];
    logic [7:0] m_cur[$];
    logic [7:0] acc_log[$];
    logic       m_pend = 1'b0;
    logic       m_done = 1'b0;
    logic       m_trig;

    task automatic checkOutput(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [7:0] to_ascii(input logic [3:0] d);
        return (d <= 4'd9) ? (8'h30 + {4'h0, d}) : 8'h3F;
    endfunction

    // Reference model: a new frame is the string of the current digits.
    task automatic start_frame();
        logic [7:0] f[$];
        f.push_back(to_ascii(hr_tens));
        f.push_back(to_ascii(hr_ones));
`ifdef TIME_REPORTER_COLON_EN
        f.push_back(8'h3A);
`endif
        f.push_back(to_ascii(min_tens));
        f.push_back(to_ascii(min_ones));
`ifdef TIME_REPORTER_COLON_EN
        f.push_back(8'h3A);
`endif
        f.push_back(to_ascii(sec_tens));
        f.push_back(to_ascii(sec_ones));
        f.push_back(8'h0A);
        foreach (f[i]) begin
            m_cur.push_back(f[i]);
            exp_q.push_back(f[i]);
        end
    endtask

    // Model steps once per clock on the stimulus the DUT also samples.
    always @(posedge clk) begin
        m_trig = send | sec_tick;
        m_done = 1'b0;
        if (reset) begin
            m_cur.delete();
            exp_q.delete();
            m_pend = 1'b0;
        end else if (m_cur.size() == 0) begin
            if (m_trig) start_frame();
        end else if (tx.tx_ready) begin
            void'(m_cur.pop_front());
            if (m_cur.size() == 0) begin
                m_done = 1'b1;
                m_done_cnt++;
                if (m_pend || m_trig) begin
                    m_pend = 1'b0;
                    start_frame();
                end
            end else if (m_trig) begin
                m_pend = 1'b1;
            end
        end else if (m_trig) begin
            m_pend = 1'b1;
        end
    end

    // Monitor: compare status each cycle and pop the scoreboard on every accepted byte.
    always @(negedge clk) begin
        checkOutput("busy", {7'b0, busy}, {7'b0, (m_cur.size() != 0)});
        checkOutput("tx_valid", {7'b0, tx.tx_valid}, {7'b0, (m_cur.size() != 0)});
        checkOutput("done", {7'b0, done}, {7'b0, m_done});
        if (m_cur.size() != 0) checkOutput("tx_data", tx.tx_data, m_cur[0]);
        if (done === 1'b1) dut_done_cnt++;
        if (tx.tx_valid === 1'b1 && tx.tx_ready === 1'b1) begin
            acc_log.push_back(tx.tx_data);
            if (exp_q.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("[TB] FAIL sb_underflow: got byte %h expected none at %0t", tx.tx_data, $time);
            end else begin
                checkOutput("sb_byte", tx.tx_data, exp_q.pop_front());
            end
        end
    end

    task automatic applyStimulus(input logic r, input logic s, input logic t, input logic rdy);
        @(posedge clk);
        #2;
        reset       = r;
        send        = s;
        sec_tick    = t;
        tx.tx_ready = rdy;
    endtask

    task automatic set_digits(input logic [3:0] a, b, c, d, e, f);
        hr_tens = a; hr_ones = b; min_tens = c; min_ones = d; sec_tens = e; sec_ones = f;
    endtask

    task automatic idle(input int n);
        repeat (n) applyStimulus(1'b0, 1'b0, 1'b0, 1'b1);
    endtask

    task automatic check_golden(input string name);
        logic [7:0] golden[$];
`ifdef TIME_REPORTER_COLON_EN
        golden = '{8'h31, 8'h32, 8'h3A, 8'h33, 8'h34, 8'h3A, 8'h35, 8'h36, 8'h0A};
`else
        golden = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h0A};
`endif
        checkOutput({name, "_len"}, 8'(acc_log.size()), 8'(golden.size()));
        foreach (golden[i]) begin
            if (i < acc_log.size()) checkOutput($sformatf("%s_byte%0d", name, i), acc_log[i], golden[i]);
        end
    endtask

    int d0;
    int budget;

    initial begin
        reset = 1'b1; send = 1'b0; sec_tick = 1'b0; tx.tx_ready = 1'b0;
        set_digits(4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6);
        repeat (3) applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
        idle(2);

        // Basic frame at full rate.
        acc_log.delete();
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b1);
        idle(FLEN + 3);
        check_golden("t1");

        // Ready toggling: bytes hold while stalled.
        acc_log.delete();
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 2 * FLEN + 4; i++) applyStimulus(1'b0, 1'b0, 1'b0, logic'(i % 2));
        idle(3);
        check_golden("t2");

        // Digits change mid-frame; snapshot must hold.
        acc_log.delete();
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b1);
        idle(2);
        set_digits(4'd2, 4'd3, 4'd5, 4'd9, 4'd5, 4'd9);
        idle(FLEN + 2);
        check_golden("t3");
        set_digits(4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6);

        // Two sends mid-frame coalesce into one follow-up frame.
        d0 = dut_done_cnt;
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b1);
        for (int k = 1; k < 2 * FLEN + 6; k++) applyStimulus(1'b0, logic'(k == 2 || k == 4), 1'b0, 1'b1);
        checkOutput("t4_done_pulses", 8'(dut_done_cnt - d0), 8'd2);

        // Invalid digit then reset mid-frame.
        acc_log.delete();
        d0 = dut_done_cnt;
        set_digits(4'hA, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6);
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b1);
        idle(3);
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b1);
        idle(6);
        checkOutput("t5_first_byte", (acc_log.size() > 0) ? acc_log[0] : 8'hXX, 8'h3F);
        checkOutput("t5_no_done", 8'(dut_done_cnt - d0), 8'd0);
        set_digits(4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6);

        // send and sec_tick together give a single frame.
        acc_log.delete();
        d0 = dut_done_cnt;
        applyStimulus(1'b0, 1'b1, 1'b1, 1'b1);
        idle(FLEN + 4);
        checkOutput("t6_done_pulses", 8'(dut_done_cnt - d0), 8'd1);
        check_golden("t6");

        // Randomized traffic.
        for (int i = 0; i < 800; i++) begin
            applyStimulus(logic'($urandom_range(0, 299) == 0),
                          logic'($urandom_range(0, 19) == 0),
                          logic'($urandom_range(0, 29) == 0),
                          logic'($urandom_range(0, 3) != 0));
            if ($urandom_range(0, 7) == 0)
                set_digits(4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
                           4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)));
        end

        // Drain outstanding frames with a bounded wait.
        budget = 0;
        while ((m_cur.size() != 0 || m_pend) && budget < 100) begin
            idle(1);
            budget++;
        end
        if (budget >= 100) begin
            n_tests++;
            n_fail++;
            $display("[TB] FAIL drain_timeout: got %0d bytes left expected 0", m_cur.size());
        end
        idle(3);
        checkOutput("sb_empty", 8'(exp_q.size()), 8'd0);
        checkOutput("done_total", 8'(dut_done_cnt), 8'(m_done_cnt));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
